// File: rtl/audio_pwm_env.sv
// audio_pwm_env: 8-bit PWM audio output whose duty is the synchronized
// 4-bit waveform sample scaled by a 4-bit attack/sustain/release envelope.
// Duty is latched once per 256-cycle PWM period, so envelope steps never
// disturb a period that is already in progress.
module audio_pwm_env #(
  parameter int unsigned ENV_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sample,
  input  logic       gate,
  output logic       pwm_out,
  output logic [3:0] level,
  output logic       busy,
  output logic       period_start
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_e;

  // Divider terminal count; 20 bits covers the largest legal ENV_DIV.
  localparam logic [19:0] DIV_LAST = 20'(ENV_DIV - 1);

  logic [3:0]  sample_m_q;
  logic [3:0]  sample_s_q;
  logic        gate_m_q;
  logic        gate_s_q;

  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [7:0]  duty_q;
  logic [7:0]  duty_d;
  logic        pwm_q;
  logic        pwm_d;
  logic [19:0] div_q;
  logic [19:0] div_d;
  logic        period_end;
  logic        tick;

  env_state_e  state_q;
  logic [3:0]  level_q;

  // Next-state logic for the PWM counter, duty latch, compare and envelope divider.
  always_comb begin
    period_end = (cnt_q == 8'hFF);
    cnt_d      = cnt_q + 8'd1;
    duty_d     = duty_q;
    if (period_end) begin
      duty_d = {4'd0, sample_s_q} * {4'd0, level_q};
    end
    pwm_d = (cnt_q < duty_q);
    tick  = (div_q == DIV_LAST);
    div_d = tick ? 20'd0 : div_q + 20'd1;
  end

  // Input synchronizers, PWM counter, duty latch, registered PWM compare and divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_m_q <= '0;
      sample_s_q <= '0;
      gate_m_q   <= 1'b0;
      gate_s_q   <= 1'b0;
      cnt_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
      div_q      <= '0;
    end else begin
      sample_m_q <= sample;
      sample_s_q <= sample_m_q;
      gate_m_q   <= gate;
      gate_s_q   <= gate_m_q;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      div_q      <= div_d;
    end
  end

  // Envelope FSM: a gate-driven transition wins over a coincident tick,
  // and the level saturates at 0 and 15 instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          level_q <= '0;
          if (gate_s_q) begin
            state_q <= ATTACK;
          end
        end
        ATTACK: begin
          if (!gate_s_q) begin
            state_q <= RELEASE;
          end else if (tick) begin
            if (level_q == 4'd15) begin
              state_q <= SUSTAIN;
            end else begin
              level_q <= level_q + 4'd1;
              if (level_q == 4'd14) begin
                state_q <= SUSTAIN;
              end
            end
          end
        end
        SUSTAIN: begin
          level_q <= 4'd15;
          if (!gate_s_q) begin
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (gate_s_q) begin
            state_q <= ATTACK;
          end else if (tick) begin
            if (level_q == 4'd0) begin
              state_q <= IDLE;
            end else begin
              level_q <= level_q - 4'd1;
              if (level_q == 4'd1) begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= '0;
        end
      endcase
    end
  end

  assign pwm_out      = pwm_q;
  assign level        = level_q;
  assign busy         = (state_q != IDLE);
  assign period_start = period_end & ~rst;

endmodule
